serial_tx: RTL and testbench
============================

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, payload bits per frame (>=1).
REQ-002 SHALL have parameter CLKS_PER_BIT, default 4, clock cycles per serial bit (>=1).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  producer holds a word for transmission.
REQ-006 SHALL have port in_data  input  DATA_WIDTH  word to transmit, LSB first.
REQ-007 SHALL have port in_ready  output  1  block can accept a word this cycle.
REQ-008 SHALL have port tx  output  1  serial line, idle high.
REQ-009 SHALL have port busy  output  1  high while a frame is in flight.

Function
REQ-010 SHALL transfer a word on a posedge where in_valid && in_ready are both 1; no transfer otherwise.
REQ-011 SHALL drive in_ready = 1 only in IDLE with rst_n high; 0 in all other states.
REQ-012 SHALL latch in_data into an internal shift register on transfer; later in_data changes do not affect the frame.
REQ-013 SHALL use FSM states IDLE, START, DATA, STOP.
REQ-014 SHALL make these transitions: IDLE->START on transfer; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after DATA_WIDTH bits; STOP->IDLE after CLKS_PER_BIT cycles.
REQ-015 SHALL register tx: 1 in IDLE, 0 in START, current data bit in DATA, 1 in STOP.
REQ-016 SHALL hold each bit for exactly CLKS_PER_BIT cycles, with tx changing on the transfer edge (start bit visible the cycle after transfer).
REQ-017 SHALL send the frame as start bit 0, then in_data[0] .. in_data[DATA_WIDTH-1], then stop bit 1: (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
REQ-018 SHALL drive busy = 1 in START, DATA and STOP, and 0 in IDLE.
REQ-019 SHALL spend at least one cycle in IDLE between frames, so back-to-back frames are separated by exactly one idle-high cycle when in_valid is held.
REQ-020 SHALL ignore in_valid while busy; there is no queuing and no error flag.
REQ-021 SHALL size the cycle counter as $clog2(CLKS_PER_BIT) bits (minimum 1) and the bit counter as $clog2(DATA_WIDTH) bits (minimum 1); neither counter may wrap within a bit or frame.
REQ-022 SHALL behave correctly with CLKS_PER_BIT=1: one cycle per bit, no counter stall.

Reset
REQ-023 SHALL on a posedge with rst_n=0 set state IDLE, tx=1, busy=0 and counters to 0, and clear the shift register to 0.
REQ-024 SHALL force in_ready = 0 while rst_n=0, regardless of state.
REQ-025 SHALL abort any frame in flight when reset occurs mid-frame; the line returns high, and the frame is neither resumed nor retransmitted.
REQ-026 SHALL honour in_valid on the first posedge after rst_n returns high.

Structure
REQ-027 SHALL place the tx_state_t enum (IDLE, START, DATA, STOP) and the default DATA_WIDTH/CLKS_PER_BIT localparams in shared package serial_pkg.
REQ-028 SHALL implement bit timing in one sub-module, bit_timer (clk, rst_n, en, bit_done pulse on the final cycle of each bit); the FSM and shift register live in serial_tx.

Verification
REQ-029 SHALL cover reset: rst_n low 2 cycles with in_valid=1 -> tx=1, busy=0, in_ready=0 during reset; in_ready=1 the first cycle after release.
REQ-030 SHALL cover a single frame: send 8'hA5 (DATA_WIDTH=8, CLKS_PER_BIT=4) -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles, 40 cycles total; busy high and in_ready low throughout.
REQ-031 SHALL cover back-to-back frames: in_valid held with 8'h3C after 8'hA5 -> exactly one idle-high cycle, then a start bit and LSB-first 0,0,1,1,1,1,0,0.
REQ-032 SHALL cover data stability: in_data changed to 8'hFF one cycle after transfer of 8'h00 -> all eight data bits transmitted as 0.
REQ-033 SHALL cover reset mid-frame: rst_n low for 1 cycle during data bit 3 -> tx=1 and busy=0 on that edge, and no further low bits until a new transfer.
REQ-034 SHALL cover the minimum timing case: instance with CLKS_PER_BIT=1 sending 8'h00 -> tx low for 9 consecutive cycles, then high; frame length 10 cycles.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and default parameters for the serial transmitter slice.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int DEFAULT_DATA_WIDTH   = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 4;

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Per-bit cycle counter: bit_done marks the final clock of every serial bit
// while enabled, and the count restarts at zero for the next bit.
module bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bit_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_done = en && (cnt_q == CNT_LAST);
    if (!en) begin
      cnt_d = '0;
    end else if (bit_done) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// UART-style serial transmitter: start bit 0, DATA_WIDTH bits LSB first,
// stop bit 1, each bit held CLKS_PER_BIT cycles; tx idles high.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  tx,
  output logic                  busy
);

  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

  tx_state_t             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  bit_done;
  logic                  transfer;

  // in_ready is combinational on rst_n so it is low for the whole reset cycle
  assign in_ready = rst_n && (state_q == IDLE);
  assign transfer = in_valid && in_ready;
  assign tx       = tx_q;
  assign busy     = busy_q;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state_q != IDLE),
    .bit_done (bit_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (transfer) state_d = START; else state_d = IDLE;
      START:   if (bit_done) state_d = DATA;  else state_d = START;
      DATA:    if (bit_done && (bit_cnt_q == BIT_LAST)) state_d = STOP; else state_d = DATA;
      STOP:    if (bit_done) state_d = IDLE;  else state_d = STOP;
      default: state_d = IDLE;
    endcase
  end

  // tx_d is the value of the line for the cycle after this edge, so each
  // bit is loaded on the final cycle of the bit before it
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          shift_d   = in_data;
          bit_cnt_d = '0;
          tx_d      = 1'b0;
        end else begin
          tx_d = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1'b1;
        end else begin
          tx_d = 1'b0;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (bit_cnt_q == BIT_LAST) begin
            tx_d = 1'b1;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1'b1;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end else begin
          tx_d = tx_q;
        end
      end
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: an 8-bit/4-clock instance and an 8-bit/1-clock instance.
module tb_serial_tx;

  logic       clk;
  logic       rst_n;
  logic       in_valid, in_valid1;
  logic [7:0] in_data, in_data1;
  logic       in_ready, in_ready1;
  logic       tx, tx1;
  logic       busy, busy1;

  int vecs = 0;
  int errs = 0;

  serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .tx(tx), .busy(busy)
  );

  serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_data(in_data1),
    .in_ready(in_ready1), .tx(tx1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      vecs++; if (tx !== 1'b1)       begin errs++; $display("FAIL reset_tx cyc%0d got %b exp 1", c, tx); end
      vecs++; if (busy !== 1'b0)     begin errs++; $display("FAIL reset_busy cyc%0d got %b exp 0", c, busy); end
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL reset_ready cyc%0d got %b exp 0", c, in_ready); end
    end
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL release_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_single_frame();
    logic [9:0] frame;
    frame = {1'b1, 8'hA5, 1'b0};
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'hA5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      vecs++; if (tx !== frame[i/4]) begin errs++; $display("FAIL frame_a5_tx cyc%0d got %b exp %b", i, tx, frame[i/4]); end
      vecs++; if (busy !== 1'b1)     begin errs++; $display("FAIL frame_a5_busy cyc%0d got %b exp 1", i, busy); end
      vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL frame_a5_ready cyc%0d got %b exp 0", i, in_ready); end
      @(posedge clk); #1;
    end
    vecs++; if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1)
      begin errs++; $display("FAIL frame_a5_end got tx=%b busy=%b rdy=%b exp 1 0 1", tx, busy, in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [9:0] f1, f2;
    f1 = {1'b1, 8'hA5, 1'b0};
    f2 = {1'b1, 8'h3C, 1'b0};
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'hA5;
    @(posedge clk); #1;
    in_data = 8'h3C;
    for (int i = 0; i < 40; i++) begin
      vecs++; if (tx !== f1[i/4]) begin errs++; $display("FAIL b2b_first_tx cyc%0d got %b exp %b", i, tx, f1[i/4]); end
      @(posedge clk); #1;
    end
    vecs++; if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b1)
      begin errs++; $display("FAIL b2b_gap got tx=%b busy=%b rdy=%b exp 1 0 1", tx, busy, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      vecs++; if (tx !== f2[i/4]) begin errs++; $display("FAIL b2b_second_tx cyc%0d got %b exp %b", i, tx, f2[i/4]); end
      vecs++; if (busy !== 1'b1)  begin errs++; $display("FAIL b2b_second_busy cyc%0d got %b exp 1", i, busy); end
      @(posedge clk); #1;
    end
    vecs++; if (tx !== 1'b1 || busy !== 1'b0)
      begin errs++; $display("FAIL b2b_end got tx=%b busy=%b exp 1 0", tx, busy); end
  endtask

  task automatic test_data_stability();
    logic [9:0] frame;
    frame = {1'b1, 8'h00, 1'b0};
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'h00;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 8'hFF;
    for (int i = 0; i < 40; i++) begin
      vecs++; if (tx !== frame[i/4]) begin errs++; $display("FAIL stable_tx cyc%0d got %b exp %b", i, tx, frame[i/4]); end
      @(posedge clk); #1;
    end
    vecs++; if (tx !== 1'b1 || busy !== 1'b0)
      begin errs++; $display("FAIL stable_end got tx=%b busy=%b exp 1 0", tx, busy); end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] frame;
    frame = {1'b1, 8'hA5, 1'b0};
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'hA5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 17; i++) begin
      vecs++; if (tx !== frame[i/4]) begin errs++; $display("FAIL midrst_pre_tx cyc%0d got %b exp %b", i, tx, frame[i/4]); end
      @(posedge clk); #1;
    end
    vecs++; if (tx !== 1'b0 || busy !== 1'b1)
      begin errs++; $display("FAIL midrst_bit3 got tx=%b busy=%b exp 0 1", tx, busy); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    vecs++; if (tx !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0)
      begin errs++; $display("FAIL midrst_edge got tx=%b busy=%b rdy=%b exp 1 0 0", tx, busy, in_ready); end
    rst_n = 1'b1;
    for (int i = 0; i < 44; i++) begin
      @(posedge clk); #1;
      vecs++; if (tx !== 1'b1 || busy !== 1'b0)
        begin errs++; $display("FAIL midrst_after cyc%0d got tx=%b busy=%b exp 1 0", i, tx, busy); end
    end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL midrst_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_min_timing();
    @(posedge clk); #1;
    in_valid1 = 1'b1; in_data1 = 8'h00;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vecs++; if (tx1 !== ((i < 9) ? 1'b0 : 1'b1)) begin errs++; $display("FAIL min_tx cyc%0d got %b exp %b", i, tx1, (i < 9) ? 1'b0 : 1'b1); end
      vecs++; if (busy1 !== 1'b1) begin errs++; $display("FAIL min_busy cyc%0d got %b exp 1", i, busy1); end
      @(posedge clk); #1;
    end
    vecs++; if (tx1 !== 1'b1 || busy1 !== 1'b0 || in_ready1 !== 1'b1)
      begin errs++; $display("FAIL min_end got tx=%b busy=%b rdy=%b exp 1 0 1", tx1, busy1, in_ready1); end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    in_valid1 = 1'b0; in_data1 = 8'h00;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_data_stability();
    test_reset_mid_frame();
    test_min_timing();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
